// File: rtl/maab_acc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maab_acc_pipe : pipelined R = a*b + c + d (Karatsuba) + accumulator  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module maab_acc_pipe #(
  parameter int W = 64,
  parameter int G = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic             mode,
  input  logic             first,
  output logic             out_valid,
  output logic [2*W+G-1:0] p,
  output logic             ovf
);
  localparam int H  = W / 2;
  localparam int PW = 2 * W + G;

  logic [H-1:0] w_al, w_ah, w_bl, w_bh;
  assign w_al = a[H-1:0];
  assign w_ah = a[W-1:H];
  assign w_bl = b[H-1:0];
  assign w_bh = b[W-1:H];

  logic [W-1:0] r1_ll, r1_hh;
  logic [H:0]   r1_s, r1_t;
  logic [W:0]   r1_cd;
  logic         r1_v, r1_mode, r1_first;

  logic [W+1:0] r2_mid, r2_low;
  logic [W:0]   r2_nsum;
  logic [W-1:0] r2_hh;
  logic         r2_v, r2_mode, r2_first;

  logic [2*W-1:0] r3_r;
  logic           r3_v, r3_mode, r3_first;

  logic [PW-1:0] r_acc;

  // Subtracting both half products: mid = sL*tL + ~(ll+hh) + 1 in W+2 bits
  logic [W+1:0]   w3_mid;
  logic [2*W-1:0] w3_r;
  assign w3_mid = r2_mid + {1'b1, r2_nsum} + {{(W+1){1'b0}}, 1'b1};
  assign w3_r   = {{(W-2){1'b0}}, r2_low}
                + ({{(W-2){1'b0}}, w3_mid} << H)
                + {r2_hh, {W{1'b0}}};

  always_ff @(posedge clk) begin
    r1_ll    <= {{H{1'b0}}, w_al} * {{H{1'b0}}, w_bl};
    r1_hh    <= {{H{1'b0}}, w_ah} * {{H{1'b0}}, w_bh};
    r1_s     <= {1'b0, w_ah} + {1'b0, w_al};
    r1_t     <= {1'b0, w_bh} + {1'b0, w_bl};
    r1_cd    <= {1'b0, c} + {1'b0, d};
    r1_mode  <= mode;
    r1_first <= first;

    r2_mid   <= {{(H+1){1'b0}}, r1_s} * {{(H+1){1'b0}}, r1_t};
    r2_low   <= {2'b00, r1_ll} + {1'b0, r1_cd};
    r2_nsum  <= ~({1'b0, r1_ll} + {1'b0, r1_hh});
    r2_hh    <= r1_hh;
    r2_mode  <= r1_mode;
    r2_first <= r1_first;

    r3_r     <= w3_r;
    r3_mode  <= r2_mode;
    r3_first <= r2_first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
      r3_v <= 1'b0;
    end else begin
      r1_v <= in_valid;
      r2_v <= r1_v;
      r3_v <= r2_v;
    end
  end

  logic [PW:0] w_sum;
  assign w_sum = {1'b0, r_acc} + {{(G+1){1'b0}}, r3_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
      r_acc     <= '0;
    end else begin
      out_valid <= r3_v;
      if (r3_v) begin
        if (!r3_mode) begin
          p <= {{G{1'b0}}, r3_r};
        end else if (r3_first) begin
          r_acc <= {{G{1'b0}}, r3_r};
          p     <= {{G{1'b0}}, r3_r};
          ovf   <= 1'b0;
        end else begin
          r_acc <= w_sum[PW-1:0];
          p     <= w_sum[PW-1:0];
          ovf   <= ovf | w_sum[PW];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_maab_acc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maab_acc_pipe : vector tables + random beats vs reference model   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_maab_acc_pipe;
  typedef struct packed {
    logic v; logic [63:0] a, b, c, d; logic mode, first;
  } beat_t;
  typedef struct packed {
    logic v; logic [135:0] p; logic ovf;
  } out_t;
  typedef struct packed {
    beat_t bt; out_t ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic iv64, mo64, fi64, ov64, of64;
  logic [63:0] a64, b64, c64, d64;
  logic [135:0] p64;
  logic iv8, mo8, fi8, ov8, of8;
  logic [7:0] a8, b8, c8, d8;
  logic [17:0] p8;

  maab_acc_pipe #(.W(64), .G(8)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .a(a64), .b(b64), .c(c64), .d(d64),
    .mode(mo64), .first(fi64), .out_valid(ov64), .p(p64), .ovf(of64));
  maab_acc_pipe #(.W(8), .G(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .c(c8), .d(d8),
    .mode(mo8), .first(fi8), .out_valid(ov8), .p(p8), .ovf(of8));

  int nchk = 0, nfail = 0, cyc = 0;
  out_t q64[$], q8[$];
  logic [135:0] acc64, mp64, acc8, mp8;
  logic movf64, movf8;
  beat_t idle;
  out_t zero;

  function automatic beat_t mk(input logic v, input logic [63:0] a, b, c, d,
                               input logic mode, first);
    beat_t x;
    x.v = v; x.a = a; x.b = b; x.c = c; x.d = d; x.mode = mode; x.first = first;
    return x;
  endfunction

  function automatic out_t ex(input logic v, input logic [135:0] p, input logic ovf);
    out_t o;
    o.v = v; o.p = p; o.ovf = ovf;
    return o;
  endfunction

  // Reference: exact a*b+c+d in wide arithmetic, accumulate modulo 2^(2W+G)
  task automatic model(input int w, input int g, input beat_t x,
                       inout logic [135:0] acc, inout logic [135:0] pv,
                       inout logic of, output out_t o);
    logic [135:0] wm, r;
    logic [136:0] pm, s;
    wm = (136'(1) << w) - 136'(1);
    pm = (137'(1) << (2 * w + g)) - 137'(1);
    r  = ({72'b0, x.a} & wm) * ({72'b0, x.b} & wm) + ({72'b0, x.c} & wm) + ({72'b0, x.d} & wm);
    if (x.v) begin
      if (!x.mode) pv = r;
      else if (x.first) begin acc = r; of = 1'b0; pv = r; end
      else begin
        s   = {1'b0, acc} + {1'b0, r};
        of  = of | ((s >> (2 * w + g)) != 137'(0));
        acc = 136'(s & pm);
        pv  = acc;
      end
    end
    o = ex(x.v, pv, of);
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s cyc %0d: got v=%0b p=%0h ovf=%0b, expected v=%0b p=%0h ovf=%0b",
               name, cyc, got.v, got.p, got.ovf, exp.v, exp.p, exp.ovf);
    end
  endtask

  task automatic drive(input beat_t x64, input beat_t x8);
    iv64 = x64.v; a64 = x64.a; b64 = x64.b; c64 = x64.c; d64 = x64.d;
    mo64 = x64.mode; fi64 = x64.first;
    iv8 = x8.v; a8 = x8.a[7:0]; b8 = x8.b[7:0]; c8 = x8.c[7:0]; d8 = x8.d[7:0];
    mo8 = x8.mode; fi8 = x8.first;
  endtask

  task automatic reset_model();
    acc64 = '0; mp64 = '0; movf64 = 1'b0;
    acc8 = '0; mp8 = '0; movf8 = 1'b0;
    q64.delete(); q8.delete();
    repeat (4) begin q64.push_back(zero); q8.push_back(zero); end
  endtask

  // One cycle: compare the beat issued 4 cycles ago, then issue a new one
  task automatic step(input beat_t x64, input beat_t x8, input bit t64, input out_t e64,
                      input bit t8, input out_t e8);
    out_t m;
    @(posedge clk); #1;
    cyc++;
    if (q64.size() == 4) check("u64", ex(ov64, p64, of64), q64.pop_front());
    if (q8.size() == 4) check("u8", ex(ov8, {118'b0, p8}, of8), q8.pop_front());
    drive(x64, x8);
    model(64, 8, x64, acc64, mp64, movf64, m);
    q64.push_back(t64 ? e64 : m);
    model(8, 2, x8, acc8, mp8, movf8, m);
    q8.push_back(t8 ? e8 : m);
  endtask

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic beat_t rb();
    return mk($urandom_range(0, 9) < 8, rv(), rv(), rv(), rv(),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
  endfunction

  vec_t t64[13];
  vec_t t8[8];
  localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    zero = ex(0, 0, 0);
    t64[0]  = '{mk(1, M64, M64, M64, M64, 0, 0), ex(1, (136'(1) << 128) - 136'(1), 0)};
    t64[1]  = '{mk(1, 2, 3, 1, 0, 0, 0), ex(1, 7, 0)};
    t64[2]  = '{mk(1, 0, 7, 5, 5, 0, 0), ex(1, 10, 0)};
    t64[3]  = '{mk(1, 64'h1_0000_0000, 64'h1_0000_0000, 0, 1, 0, 0), ex(1, (136'(1) << 64) + 136'(1), 0)};
    t64[4]  = '{idle, ex(0, (136'(1) << 64) + 136'(1), 0)};
    t64[5]  = '{mk(1, 1, 1, 1, 1, 0, 0), ex(1, 3, 0)};
    t64[6]  = '{mk(1, 10, 10, 0, 0, 1, 1), ex(1, 100, 0)};
    t64[7]  = '{mk(1, 5, 5, 0, 0, 1, 0), ex(1, 125, 0)};
    t64[8]  = '{mk(1, 0, 0, 3, 4, 1, 0), ex(1, 132, 0)};
    t64[9]  = '{mk(1, 1, 1, 0, 0, 1, 1), ex(1, 1, 0)};
    t64[10] = '{mk(1, 3, 3, 0, 0, 1, 1), ex(1, 9, 0)};
    t64[11] = '{mk(1, 4, 4, 0, 0, 0, 0), ex(1, 16, 0)};
    t64[12] = '{mk(1, 2, 2, 0, 0, 1, 0), ex(1, 13, 0)};
    t8[0] = '{mk(1, 255, 255, 255, 255, 1, 1), ex(1, 65535, 0)};
    t8[1] = '{mk(1, 255, 255, 255, 255, 1, 0), ex(1, 131070, 0)};
    t8[2] = '{mk(1, 255, 255, 255, 255, 1, 0), ex(1, 196605, 0)};
    t8[3] = '{mk(1, 255, 255, 255, 255, 1, 0), ex(1, 262140, 0)};
    t8[4] = '{mk(1, 255, 255, 255, 255, 1, 0), ex(1, 65531, 1)};
    t8[5] = '{idle, ex(0, 65531, 1)};
    t8[6] = '{mk(1, 1, 1, 0, 0, 0, 0), ex(1, 1, 1)};
    t8[7] = '{mk(1, 2, 2, 0, 0, 1, 1), ex(1, 4, 0)};

    rst_n = 1'b0;
    drive(idle, idle);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("u64 in reset", ex(ov64, p64, of64), zero);
    check("u8 in reset", ex(ov8, {118'b0, p8}, of8), zero);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) step(t64[i].bt, idle, 1, t64[i].ex, 0, zero);
    repeat (4) step(idle, idle, 0, zero, 0, zero);
    for (int i = 0; i < 8; i++) step(idle, t8[i].bt, 0, zero, 1, t8[i].ex);
    repeat (4) step(idle, idle, 0, zero, 0, zero);

    // Reset with two beats in flight: outputs clear at once, beats vanish
    step(mk(1, 6, 6, 0, 0, 1, 1), mk(1, 6, 6, 0, 0, 1, 1), 0, zero, 0, zero);
    step(mk(1, 7, 7, 0, 0, 1, 0), mk(1, 7, 7, 0, 0, 1, 0), 0, zero, 0, zero);
    #2 rst_n = 1'b0;
    drive(idle, idle);
    #1;
    check("u64 async reset", ex(ov64, p64, of64), zero);
    check("u8 async reset", ex(ov8, {118'b0, p8}, of8), zero);
    reset_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(mk(1, 3, 3, 0, 0, 1, 0), mk(1, 3, 3, 0, 0, 1, 0), 1, ex(1, 9, 0), 1, ex(1, 9, 0));
    repeat (4) step(idle, idle, 0, zero, 0, zero);

    repeat (600) step(rb(), rb(), 0, zero, 0, zero);
    repeat (4) step(idle, idle, 0, zero, 0, zero);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/maab_acc_pipe.md
Name: maab_acc_pipe

Overview:
- Parametrised, valid-qualified successor to the fixed 64-bit multiply-add-add core.
- Computes R = a*b + c + d exactly on W-bit unsigned operands through a 3-stage Karatsuba pipeline.
- A 4th stage either passes R through or accumulates it into a guarded running sum.
- Sits in the cp_core datapath, feeding inner-product and quadratic-form reductions.

Parameters:
W, 64, operand width; even, >= 8; H = W/2 is the Karatsuba half width.
G, 8, accumulator guard bits above 2W.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat on a/b/c/d/mode/first is valid this cycle
a  input  W  multiplicand, unsigned
b  input  W  multiplier, unsigned
c  input  W  addend, unsigned
d  input  W  addend, unsigned
mode  input  1  0 = pass-through, 1 = accumulate
first  input  1  mode=1 only: start a new sum with this beat
out_valid  output  1  p/ovf valid this cycle
p  output  2W+G  result: zero-extended R (mode 0) or accumulator (mode 1)
ovf  output  1  sticky accumulator wrap flag

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset state: out_valid=0, p=0, ovf=0, accumulator=0, all pipeline valid bits=0.
- Reset mid-operation drops every in-flight beat; nothing emerges after release.
- Datapath registers need no reset; valid bits, accumulator, p and ovf do.
- No backpressure. One beat per cycle accepted. Fixed latency 4: a beat at edge n gives out_valid=1 after edge n+4.
- Bubbles (in_valid=0) propagate as out_valid=0 and never change the accumulator or ovf.
- Stage 1: split a, b into halves aH/aL, bH/bL.
  - Register aL*bL (W bits), aH*bH (W bits), sL=aH+aL and tL=bH+bL (H+1 bits each), c+d (W+1 bits).
  - Also register valid, mode, first.
- Stage 2:
  - Register the mid product sL*tL (W+2 bits).
  - Register low + (c+d) (W+2 bits).
  - Register ~(aL*bL + aH*bH) (W+1 bits).
  - Forward aH*bH.
- Stage 3:
  - Form mid = sL*tL - aL*bL - aH*bH as a sign-extended add with +1 (two's complement).
  - Add mid at bit offset H to the stage-2 low sum.
  - Add aH*bH at offset W.
  - R is exactly 2W bits; no truncation is permitted, since max R = 2^2W - 1.
- Stage 4:
  - mode=0: p <= {G'b0, R}; accumulator and ovf untouched.
  - mode=1, first=1: acc <= R, ovf <= 0, p <= R.
  - mode=1, first=0: acc <= acc + R mod 2^(2W+G). ovf <= ovf | carry-out. p <= new acc.
  - mode=1, first=0 immediately after reset continues from acc=0.
- mode and first are sampled with the beat and travel with it; changes between beats are legal every cycle.
- p and ovf hold their last value while out_valid=0.

Test Plan:
- Max operands, W=64, mode=0: a=b=c=d=2^64-1 -> after 4 cycles out_valid=1, p=2^128-1, ovf=0.
- Streaming, mode=0: (2,3,1,0), (0,7,5,5), (2^32, 2^32, 0, 1) on consecutive cycles -> p=7, 10, 2^64+1 on 3 consecutive out_valid cycles.
- Bubble: one idle cycle inserted -> one out_valid=0 gap at the matching output cycle.
- Accumulate, mode=1:
  - Beats (10,10,0,0,first=1), (5,5,0,0), (0,0,3,4) -> p=100, 125, 132.
  - Next beat (1,1,0,0,first=1) -> p=1.
- Interleave: mode=0 beat (4,4,0,0) between two mode=1 beats (3,3,0,0,first=1), (2,2,0,0):
  - p = 9, then 16, then 13.
  - Accumulator unaffected by the mode=0 beat.
- Overflow, W=8, G=2: five mode=1 beats a=b=c=d=255, first on beat 1:
  - Beats 1-4 -> p=65535, 131070, 196605, 262140, ovf=0.
  - Beat 5 -> p=65531, ovf=1.
  - Next first=1 beat clears ovf.
- Reset mid-op: rst_n low for 1 cycle while 2 beats are in flight -> out_valid, p, ovf go to 0 immediately; no output appears for those beats.
